// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register file geometry and the
// architectural register indices that decode and writeback refer to.
package mips_pkg;

    localparam int MIPS_DATA_W     = 32;
    localparam int MIPS_NREGS      = 32;
    localparam int MIPS_REG_ADDR_W = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_AT   = 1;
    localparam int REG_V0   = 2;
    localparam int REG_V1   = 3;
    localparam int REG_A0   = 4;
    localparam int REG_GP   = 28;
    localparam int REG_SP   = 29;
    localparam int REG_FP   = 30;
    localparam int REG_RA   = 31;

endpackage

// File: rtl/mips_regfile_2r1w_read_port.sv
// One read port: DEPTH:1 select over the flattened array, with the
// zero/range override taking priority over same-cycle write bypass.
module regfile_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W   = MIPS_DATA_W,
    parameter int DEPTH    = MIPS_NREGS,
    parameter int ADDR_W   = MIPS_REG_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [DEPTH*DATA_W-1:0] mem_i,
    input  logic [ADDR_W-1:0]       raddr_i,
    input  logic                    reset_i,
    input  logic                    we_i,
    input  logic [ADDR_W-1:0]       waddr_i,
    input  logic [DATA_W-1:0]       wdata_i,
    output logic [DATA_W-1:0]       rdata_o
);

    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] arr_val;
    logic              rd_blank;
    logic              wr_live;

    always_comb begin
        arr_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_i == ADDR_W'(i)) begin
                arr_val = mem_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rd_blank = ({1'b0, raddr_i} >= DEPTH_A) ||
                      ((ZERO_REG != 0) && (raddr_i == ADDR_W'(REG_ZERO)));

    // Mirror of the top-level write qualification so forwarding never
    // shows data that the array itself would refuse to store.
    assign wr_live = we_i && !reset_i &&
                     ({1'b0, waddr_i} < DEPTH_A) &&
                     !((ZERO_REG != 0) && (waddr_i == ADDR_W'(REG_ZERO)));

    always_comb begin
        rdata_o = arr_val;
        if (rd_blank) begin
            rdata_o = '0;
        end else if ((BYPASS != 0) && wr_live && (waddr_i == raddr_i)) begin
            rdata_o = wdata_i;
        end
    end

endmodule

// File: rtl/mips_regfile_2r1w.sv
// Two-read/one-write MIPS register file: flop storage, write decode,
// synchronous clear, and two bypassing combinational read ports.
module mips_regfile_2r1w
    import mips_pkg::*;
#(
    parameter int DATA_W   = MIPS_DATA_W,
    parameter int DEPTH    = MIPS_NREGS,
    parameter int ADDR_W   = MIPS_REG_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [DATA_W-1:0]       mem_d [DEPTH];
    logic [DEPTH*DATA_W-1:0] mem_flat;
    logic                    wr_en;

    assign wr_en = we && !((ZERO_REG != 0) && (waddr == ADDR_W'(REG_ZERO)));

    // Out-of-range addresses simply match no entry in the decode below.
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        always_comb begin
            mem_d[i] = mem_q[i];
            if (wr_en && (waddr == ADDR_W'(i))) begin
                mem_d[i] = wdata;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                mem_q[i] <= '0;
            end else begin
                mem_q[i] <= mem_d[i];
            end
        end

        assign mem_flat[i*DATA_W +: DATA_W] = mem_q[i];
    end

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rp1 (
        .mem_i   (mem_flat),
        .raddr_i (raddr1),
        .reset_i (reset),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .rdata_o (rdata1)
    );

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rp2 (
        .mem_i   (mem_flat),
        .raddr_i (raddr2),
        .reset_i (reset),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .rdata_o (rdata2)
    );

endmodule

// File: tb/tb_mips_regfile_2r1w.sv
// Directed bench: three register file variants share one stimulus stream,
// expectations queued per step and popped against the sampled outputs.
module tb_mips_regfile_2r1w;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] b_rd1, b_rd2;
    logic [31:0] n_rd1, n_rd2;
    logic [31:0] o_rd1, o_rd2;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mips_regfile_2r1w u_byp (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(b_rd1), .rdata2(b_rd2)
    );

    mips_regfile_2r1w #(.BYPASS(0)) u_nobyp (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(n_rd1), .rdata2(n_rd2)
    );

    mips_regfile_2r1w #(.DEPTH(24), .ADDR_W(5)) u_oor (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(o_rd1), .rdata2(o_rd2)
    );

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic got(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: got %h expected nothing", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic edge_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1;
        waddr = a;
        wdata = d;
        edge_tick();
        we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        raddr1 = 5'd5; raddr2 = 5'd31;
        @(negedge clk);
        edge_tick();
        edge_tick();
        reset = 1'b0; we = 1'b0;
        #1;
        expect_v("rst_rd1", 32'h0); got(b_rd1);
        expect_v("rst_rd2", 32'h0); got(b_rd2);
        expect_v("rst_nobyp", 32'h0); got(n_rd1);
        expect_v("rst_oor", 32'h0); got(o_rd1);

        raddr1 = 5'd3;
        wr(5'd3, 32'd3);
        expect_v("wr3_now", 32'd3); got(b_rd1);
        raddr1 = 5'd10;
        wr(5'd10, 32'd10);
        expect_v("wr10_now", 32'd10); got(b_rd1);
        raddr1 = 5'd15;
        wr(5'd15, 32'd15);
        expect_v("wr15_now", 32'd15); got(b_rd1);

        for (int i = 0; i < 3; i++) begin
            logic [4:0] seq [3];
            seq[0] = 5'd3; seq[1] = 5'd10; seq[2] = 5'd15;
            raddr1 = seq[i];
            raddr2 = seq[2-i];
            #1;
            expect_v("sweep_rd1", 32'(seq[i])); got(b_rd1);
            expect_v("sweep_rd2", 32'(seq[2-i])); got(b_rd2);
        end

        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0;
        #1;
        expect_v("zero_same", 32'h0); got(b_rd1);
        edge_tick();
        expect_v("zero_after", 32'h0); got(b_rd1);
        we = 1'b0;

        wr(5'd7, 32'h11111111);
        we = 1'b1; waddr = 5'd7; wdata = 32'h22222222;
        raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
        expect_v("byp_rd1", 32'h22222222); got(b_rd1);
        expect_v("byp_rd2", 32'h22222222); got(b_rd2);
        expect_v("nobyp_rd1_old", 32'h11111111); got(n_rd1);
        expect_v("nobyp_rd2_old", 32'h11111111); got(n_rd2);
        edge_tick();
        we = 1'b0;
        #1;
        expect_v("byp_after", 32'h22222222); got(b_rd1);
        expect_v("nobyp_rd1_new", 32'h22222222); got(n_rd1);
        expect_v("nobyp_rd2_new", 32'h22222222); got(n_rd2);

        we = 1'b1; waddr = 5'd28; wdata = 32'h5;
        raddr1 = 5'd28; raddr2 = 5'd3;
        #1;
        expect_v("oor_byp_blk", 32'h0); got(o_rd1);
        edge_tick();
        we = 1'b0;
        #1;
        expect_v("oor_rd28", 32'h0); got(o_rd1);
        expect_v("oor_reg3_kept", 32'd3); got(o_rd2);
        expect_v("full_rd28", 32'h5); got(b_rd1);
        we = 1'b1; waddr = 5'd23; wdata = 32'h17; raddr2 = 5'd23;
        #1;
        expect_v("oor23_byp", 32'h17); got(o_rd2);
        edge_tick();
        we = 1'b0;
        #1;
        expect_v("oor23_store", 32'h17); got(o_rd2);

        wr(5'd4, 32'hA5A5A5A5);
        raddr1 = 5'd4;
        #1;
        expect_v("r4_written", 32'hA5A5A5A5); got(b_rd1);
        reset = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h1;
        #1;
        expect_v("rst_byp_blk", 32'hA5A5A5A5); got(b_rd1);
        edge_tick();
        expect_v("rst_hold_rd", 32'h0); got(b_rd1);
        reset = 1'b0; we = 1'b0;
        #1;
        expect_v("rst_mid_rd1", 32'h0); got(b_rd1);
        expect_v("rst_mid_nobyp", 32'h0); got(n_rd1);
        raddr2 = 5'd7;
        #1;
        expect_v("rst_mid_r7", 32'h0); got(b_rd2);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: got %0d left expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
